// File: rtl/bus_arb.sv
// Two-port round-robin bus arbiter with fixed-latency transaction sequencing.
// Port 0 (fetch) is read-only; port 1 (LSU) may read or write. All outputs are registered.
module bus_arb #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned AD_LEN    = 32,
  parameter int unsigned LAT       = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req0_i,
  input  logic [AD_LEN-1:0]    ad0_i,
  output logic                 gnt0_o,
  output logic                 done0_o,
  input  logic                 req1_i,
  input  logic [AD_LEN-1:0]    ad1_i,
  input  logic                 we1_i,
  input  logic [BUS_WIDTH-1:0] wdata1_i,
  output logic                 gnt1_o,
  output logic                 done1_o,
  output logic [BUS_WIDTH-1:0] rdata_o,
  output logic                 busy_o,
  output logic [AD_LEN-1:0]    bus_ad_o,
  output logic                 bus_we_o,
  output logic [BUS_WIDTH-1:0] bus_wdata_o,
  input  logic [BUS_WIDTH-1:0] bus_data_i
);

  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StData} state_e;

  state_e               r_state, w_state_nxt;
  logic [CntW-1:0]      r_cnt, w_cnt_nxt;
  logic                 r_owner, w_owner_nxt;
  logic                 r_last, w_last_nxt;
  logic [AD_LEN-1:0]    r_bus_ad, w_bus_ad_nxt;
  logic                 r_bus_we, w_bus_we_nxt;
  logic [BUS_WIDTH-1:0] r_bus_wdata, w_bus_wdata_nxt;
  logic                 r_gnt0, w_gnt0_nxt;
  logic                 r_gnt1, w_gnt1_nxt;
  logic                 r_done0, w_done0_nxt;
  logic                 r_done1, w_done1_nxt;
  logic [BUS_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 w_win;

  // Winner: a lone requester wins; on a tie the port that did not win last time wins.
  assign w_win = req1_i & (~req0_i | ~r_last);

  // State register: synchronous reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_bus_ad    <= '0;
      r_bus_we    <= 1'b0;
      r_bus_wdata <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_bus_ad    <= w_bus_ad_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_gnt0      <= w_gnt0_nxt;
      r_gnt1      <= w_gnt1_nxt;
      r_done0     <= w_done0_nxt;
      r_done1     <= w_done1_nxt;
      r_rdata     <= w_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state logic: arbitrate in idle, count down latency, complete in data.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_bus_ad_nxt    = r_bus_ad;
    w_bus_we_nxt    = r_bus_we;
    w_bus_wdata_nxt = r_bus_wdata;
    w_rdata_nxt     = r_rdata;
    w_busy_nxt      = r_busy;
    w_gnt0_nxt      = 1'b0;
    w_gnt1_nxt      = 1'b0;
    w_done0_nxt     = 1'b0;
    w_done1_nxt     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req0_i || req1_i) begin
          w_owner_nxt     = w_win;
          w_last_nxt      = w_win;
          w_bus_ad_nxt    = w_win ? ad1_i : ad0_i;
          w_bus_we_nxt    = w_win & we1_i;
          w_bus_wdata_nxt = w_win ? wdata1_i : '0;
          w_gnt0_nxt      = ~w_win;
          w_gnt1_nxt      = w_win;
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = CntInit;
          w_state_nxt     = StWait;
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_nxt = StData;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      StData: begin
        // Writes leave the last read data visible.
        if (!r_bus_we) begin
          w_rdata_nxt = bus_data_i;
        end
        w_done0_nxt  = ~r_owner;
        w_done1_nxt  = r_owner;
        w_bus_we_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign gnt0_o      = r_gnt0;
  assign gnt1_o      = r_gnt1;
  assign done0_o     = r_done0;
  assign done1_o     = r_done1;
  assign rdata_o     = r_rdata;
  assign busy_o      = r_busy;
  assign bus_ad_o    = r_bus_ad;
  assign bus_we_o    = r_bus_we;
  assign bus_wdata_o = r_bus_wdata;

endmodule

// File: doc/bus_arb.md
# bus_arb

Two-port memory bus arbiter between the fetch unit (port 0, read-only) and the load/store unit (port 1, read/write). It owns the single shared core bus, grants one requester at a time with round-robin priority, and sequences each fixed-latency transaction. It returns read data and a completion pulse to the winning port.

## Interface
- BUS_WIDTH, 32, bus data width
- AD_LEN, 32, bus address width
- LAT, 2, cycles the bus needs between address presentation and data valid; must be ≥1

- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- req0_i  in  1  port 0 (fetch) read request, level
- ad0_i  in  AD_LEN  port 0 address
- gnt0_o  out  1  port 0 grant pulse
- done0_o  out  1  port 0 completion pulse
- req1_i  in  1  port 1 (LSU) request, level
- ad1_i  in  AD_LEN  port 1 address
- we1_i  in  1  port 1 write enable (1 = write)
- wdata1_i  in  BUS_WIDTH  port 1 write data
- gnt1_o  out  1  port 1 grant pulse
- done1_o  out  1  port 1 completion pulse
- rdata_o  out  BUS_WIDTH  read data, shared by both ports, qualified by doneN_o
- busy_o  out  1  high while a transaction is in flight
- bus_ad_o  out  AD_LEN  bus address
- bus_we_o  out  1  bus write strobe
- bus_wdata_o  out  BUS_WIDTH  bus write data
- bus_data_i  in  BUS_WIDTH  bus read data

## Operation
- Reset values: bus_ad_o, bus_we_o, bus_wdata_o, gnt0_o, gnt1_o, done0_o, done1_o, rdata_o and busy_o are 0.
  - state = IDLE, counter = 0, owner = 0, last = 1, so port 0 wins the first tie.
- States: IDLE → WAIT → DATA → IDLE.
- IDLE, at each edge:
  - No request: stay in IDLE.
  - One request: that port wins.
  - Both request: the port ≠ last wins.
  - On a win, register:
    - bus_ad_o ← winner address
    - bus_we_o ← we1_i if winner is 1, otherwise 0
    - bus_wdata_o ← wdata1_i if winner is 1, otherwise 0
    - gntN_o ← 1, owner ← N, last ← N, busy_o ← 1
    - counter ← LAT−1
    - go to WAIT.
- WAIT:
  - gntN_o returns to 0 (one-cycle pulse).
  - If counter = 0, go to DATA; otherwise decrement the counter.
- DATA, at its edge:
  - Read: rdata_o ← bus_data_i.
  - Write: rdata_o holds its value.
  - doneN_o ← 1 for the owner.
  - bus_we_o ← 0, busy_o ← 0, go to IDLE.
  - bus_ad_o and bus_wdata_o hold until the next grant.
- doneN_o is a one-cycle pulse, cleared at the next edge.
- Request rules:
  - Address, we1_i and wdata1_i are latched at grant; the requester may change them once gntN_o is seen.
  - Requests are sampled only in IDLE.
  - A request still high in IDLE is treated as a new request. A requester must drop reqN_i after gntN_o unless it wants another transaction.
- Round-robin: a port holding its request continuously is granted at most every other transaction when the other port also requests. No starvation.
- Reset mid-transaction: the transaction is abandoned, no done pulse is issued, and all registers take their reset values on that edge.

## Timing
- Grant edge E0 (IDLE, request high):
  - gntN_o and busy_o are high in cycle E0→E1.
  - bus_ad_o, bus_we_o and bus_wdata_o are valid from E0.
- WAIT spans LAT cycles. bus_data_i is sampled at edge E0+LAT+1.
- rdata_o and doneN_o are valid in cycle E0+LAT+1→E0+LAT+2.
- bus_we_o is high for LAT+1 cycles.
- Back-to-back: the next grant is at the earliest at E0+LAT+2. Bus period is LAT+2 cycles.
- Request-to-done latency is LAT+2 edges.

## Test plan
- Reset: hold reset_i for 2 cycles → every output is 0 and busy_o is 0. Release with no requests → outputs stay 0.
- Single fetch read, LAT=2: req0_i=1 with ad0_i=0x100 at E0; bus_data_i=0xDEADBEEF at E3 →
  - gnt0_o in cycle E0→E1
  - bus_ad_o=0x100
  - rdata_o=0xDEADBEEF and done0_o=1 in cycle E3→E4 only
- Simultaneous requests from reset, both held:
  - Grant order is 0, 1, 0, 1.
  - Grants are at E0, E4, E8, E12.
  - Each done pulse matches its owner.
- LSU write: req1_i, we1_i=1, ad1_i=0x2000, wdata1_i=0x12345678 →
  - bus_we_o=1 for 3 cycles with bus_ad_o/bus_wdata_o matching
  - done1_o pulses once
  - rdata_o is unchanged
- Reset in WAIT: assert reset_i one cycle after a grant →
  - no done pulse
  - outputs are 0
  - a following req1_i is granted normally, and last resets so port 0 wins the next tie
- Held single request: req0_i held high for 3 transactions with no port 1 request → three consecutive grants to port 0, LAT+2 cycles apart.
